seq_cla_adder_16bit: RTL and testbench



---
 rtl/seq_cla_adder_16bit.sv | 127 ++++++++++++
 tb/tb_seq_cla_adder_16bit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_cla_adder_16bit.sv
// Sequential carry-lookahead adder: one 4-bit lookahead slice is reused once per clock,
// folding each nibble's block P/G into a forwarded carry and word-level group P/G.
module seq_cla_adder_16bit #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   carryIn,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carryOut,
    output logic                   P_group,
    output logic                   G_group
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [W-1:0]      a_q, b_q, work_q;
    logic              carry_q, p_acc_q, g_acc_q;
    logic              busy_q, done_q, carry_out_q, p_group_q, g_group_q;
    logic [W-1:0]      sum_q;

    // Operands shift right each cycle so the active nibble is always bits [3:0].
    logic [3:0]        p, g, c, s;
    logic              blk_p, blk_g;
    logic              carry_d, p_acc_d, g_acc_d;
    logic [W+3:0]      work_cat;
    logic [W-1:0]      work_d;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign p[gi] = a_q[gi] ^ b_q[gi];
            assign g[gi] = a_q[gi] & b_q[gi];
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & carry_q);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);

    assign blk_p = &p;
    assign blk_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign carry_d  = blk_g | (blk_p & carry_q);
    assign p_acc_d  = p_acc_q & blk_p;
    assign g_acc_d  = blk_g | (blk_p & g_acc_q);

    // New nibble enters at the top; after NIBBLES steps the word is fully aligned.
    assign work_cat = {s, work_q};
    assign work_d   = work_cat[W+3:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            p_acc_q     <= 1'b0;
            g_acc_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            p_group_q   <= 1'b0;
            g_group_q   <= 1'b0;
        end else begin
            case (state_q)
                ADD: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    work_q  <= work_d;
                    carry_q <= carry_d;
                    p_acc_q <= p_acc_d;
                    g_acc_q <= g_acc_d;
                    if (idx_q == IDXW'(NIBBLES - 1)) begin
                        idx_q       <= '0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        sum_q       <= work_d;
                        carry_out_q <= carry_d;
                        p_group_q   <= p_acc_d;
                        g_group_q   <= g_acc_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carryIn;
                        p_acc_q <= 1'b1;
                        g_acc_q <= 1'b0;
                        work_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carryOut = carry_out_q;
    assign P_group  = p_group_q;
    assign G_group  = g_group_q;
endmodule

// File: tb/tb_seq_cla_adder_16bit.sv
// Scoreboard bench for seq_cla_adder_16bit: directed operations push hand-computed results,
// an independent monitor pops and compares on every done pulse.
module tb_seq_cla_adder_16bit;
    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        carry_in = 1'b0;
    logic        busy, done, carry_out, p_group, g_group;
    logic [15:0] sum;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        pg;
        logic        gg;
        int          edge_no;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    seq_cla_adder_16bit #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carryIn(carry_in),
        .busy(busy), .done(done), .sum(sum), .carryOut(carry_out),
        .P_group(p_group), .G_group(g_group)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("op done: sum=%h co=%b P=%b G=%b latency=%0d", sum, carry_out, p_group, g_group, cyc - e.edge_no);
                chk("sum", 32'(sum), 32'(e.sum));
                chk("carryOut", 32'(carry_out), 32'(e.co));
                chk("P_group", 32'(p_group), 32'(e.pg));
                chk("G_group", 32'(g_group), 32'(e.gg));
                chk("latency", 32'(cyc - e.edge_no), 32'(NIB));
            end
        end
    end

    task automatic push_exp(input logic [15:0] s, input logic co, input logic pg, input logic gg);
        exp_t e;
        e.sum = s; e.co = co; e.pg = pg; e.gg = gg;
        e.edge_no = cyc + 1;
        sb.push_back(e);
    endtask

    // Present start for exactly one sampling edge; returns in the first ADD cycle.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic [15:0] s, input logic co, input logic pg, input logic gg);
        @(negedge clk);
        a = ta; b = tb; carry_in = tc; start = 1'b1;
        push_exp(s, co, pg, gg);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 4 * NIB + 4; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * NIB + 4);
        end
        checks++;
    endtask

    initial begin
        int n_done;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_carryOut", 32'(carry_out), 0);
        chk("rst_P_group", 32'(p_group), 0);
        chk("rst_G_group", 32'(g_group), 0);
        rst = 1'b0;

        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("busy_after_start", 32'(busy), 1);
        wait_done();
        chk("busy_in_done", 32'(busy), 0);

        issue(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        wait_done();
        issue(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        wait_done();
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        wait_done();

        // Start while busy must be ignored; case 1 result still expected.
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        a = 16'h8000; b = 16'h8000; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        // Start held during the DONE cycle is accepted back-to-back.
        a = 16'h8000; b = 16'h8000; carry_in = 1'b0; start = 1'b1;
        push_exp(16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset at the second ADD cycle aborts the operation.
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_carryOut", 32'(carry_out), 0);
        chk("abort_P_group", 32'(p_group), 0);
        chk("abort_G_group", 32'(g_group), 0);
        n_done = 0;
        repeat (2 * NIB + 2) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 0);

        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        wait_done();

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
